// File: rtl/sram_arb_ctrl.sv
// -----------------------------------------------------------------------------
// sram_arb_ctrl
//   Arbitrated controller for one 32-bit asynchronous SRAM bank. N_PORTS masters
//   issue word accesses over a valid/ready handshake; one request is granted
//   per access (round-robin or fixed priority). The access then drives the
//   SRAM strobes for WAIT_CYCLES+1 cycles and completes with a one-cycle
//   rsp_valid pulse on the granted port. The pad tristate itself is built at
//   the top level from sram_data_o / sram_data_oe.
//
// Parameters
//   N_PORTS      number of master ports (>= 1)
//   ADDR_W       SRAM word-address width
//   WAIT_CYCLES  ACCESS-phase length minus 1, in clk cycles (>= 2)
//   FIXED_PRIO   0: round-robin, 1: fixed priority with port 0 highest
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     per-port request handshake (ready is combinational)
//   req_we/addr/be/wdata per-port request fields, port i at slice i
//   rsp_valid           per-port one-cycle completion pulse
//   rsp_rdata           read data shared by all ports, valid with rsp_valid
//   sram_*              registered SRAM pin controls (strobes active-low)
//   sram_data_i         data returned from the pad
//   busy                high while an access is in progress
// -----------------------------------------------------------------------------
module sram_arb_ctrl #(
  parameter int N_PORTS     = 2,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_PORTS-1:0]      req_valid,
  output logic [N_PORTS-1:0]      req_ready,
  input  logic [N_PORTS-1:0]      req_we,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*4-1:0]    req_be,
  input  logic [N_PORTS*32-1:0]   req_wdata,
  output logic [N_PORTS-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [3:0]              sram_be_n,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [31:0]             sram_data_o,
  output logic                    sram_data_oe,
  input  logic [31:0]             sram_data_i,
  output logic                    busy
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_WE_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_RESET   = PTR_W'(N_PORTS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;       // port owning the current access
  logic               we_q, we_d;         // current access is a write
  logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic [3:0]         sram_be_n_q, sram_be_n_d;
  logic               sram_ce_n_q, sram_ce_n_d;
  logic               sram_oe_n_q, sram_oe_n_d;
  logic               sram_we_n_q, sram_we_n_d;
  logic [31:0]        sram_data_o_q, sram_data_o_d;
  logic               sram_data_oe_q, sram_data_oe_d;
  logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;

  // ---------------------------------------------------------------------------
  // Grant selection, evaluated every cycle; only honoured while idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (FIXED_PRIO != 0) begin
      // Scan downwards so the lowest valid index wins.
      for (int i = N_PORTS - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'(i);
        end
      end
    end else begin
      // First valid port strictly after the last winner, wrapping around;
      // the last winner itself is considered last.
      for (int k = 1; k <= N_PORTS; k++) begin
        idx = (int'(rr_ptr_q) + k) % N_PORTS;
        if (!grant_valid && req_valid[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered pin controls.
  // ---------------------------------------------------------------------------
  always_comb begin
    int gi;
    gi             = int'(grant_idx);
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_d          = gnt_q;
    we_d           = we_q;
    sram_addr_d    = sram_addr_q;
    sram_be_n_d    = sram_be_n_q;
    sram_ce_n_d    = sram_ce_n_q;
    sram_oe_n_d    = sram_oe_n_q;
    sram_we_n_d    = sram_we_n_q;
    sram_data_o_d  = sram_data_o_q;
    sram_data_oe_d = sram_data_oe_q;
    rsp_valid_d    = '0;
    rsp_rdata_d    = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d        = ST_ACCESS;
          cnt_d          = '0;
          rr_ptr_d       = grant_idx;
          gnt_d          = grant_idx;
          we_d           = req_we[gi];
          sram_addr_d    = req_addr[gi*ADDR_W +: ADDR_W];
          sram_be_n_d    = ~req_be[gi*4 +: 4];
          sram_data_o_d  = req_wdata[gi*32 +: 32];
          sram_ce_n_d    = 1'b0;
          sram_oe_n_d    = req_we[gi];
          sram_we_n_d    = ~req_we[gi];
          sram_data_oe_d = req_we[gi];
        end
      end

      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          // Last access cycle: capture read data and release every strobe so
          // the following idle cycle acts as bus turnaround.
          state_d        = ST_IDLE;
          cnt_d          = '0;
          sram_ce_n_d    = 1'b1;
          sram_oe_n_d    = 1'b1;
          sram_we_n_d    = 1'b1;
          sram_data_oe_d = 1'b0;
          sram_be_n_d    = 4'hF;
          rsp_valid_d[gnt_q] = 1'b1;
          if (!we_q) begin
            rsp_rdata_d = sram_data_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // we_n rises one cycle before the end so data and address are held
          // past the write strobe's rising edge.
          if (cnt_q == CNT_WE_LAST) begin
            sram_we_n_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rr_ptr_q       <= PTR_RESET;
      gnt_q          <= '0;
      we_q           <= 1'b0;
      sram_addr_q    <= '0;
      sram_be_n_q    <= 4'hF;
      sram_ce_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
      sram_we_n_q    <= 1'b1;
      sram_data_o_q  <= '0;
      sram_data_oe_q <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_q          <= gnt_d;
      we_q           <= we_d;
      sram_addr_q    <= sram_addr_d;
      sram_be_n_q    <= sram_be_n_d;
      sram_ce_n_q    <= sram_ce_n_d;
      sram_oe_n_q    <= sram_oe_n_d;
      sram_we_n_q    <= sram_we_n_d;
      sram_data_o_q  <= sram_data_o_d;
      sram_data_oe_q <= sram_data_oe_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign sram_addr    = sram_addr_q;
  assign sram_be_n    = sram_be_n_q;
  assign sram_ce_n    = sram_ce_n_q;
  assign sram_oe_n    = sram_oe_n_q;
  assign sram_we_n    = sram_we_n_q;
  assign sram_data_o  = sram_data_o_q;
  assign sram_data_oe = sram_data_oe_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign busy         = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_arb_ctrl
//   Bench for sram_arb_ctrl. Main instance: 3 ports, round-robin, 2 wait
//   cycles, attached to a behavioural SRAM pad model. Expected responses are
//   queued when a request is accepted and compared by a monitor when the DUT
//   presents rsp_valid. A second instance (2 ports, fixed priority, 3 wait
//   cycles) exercises the priority arbiter.
// -----------------------------------------------------------------------------
module tb_sram_arb_ctrl;

  localparam int NP = 3;
  localparam int AW = 20;
  localparam int W  = 2;
  localparam int W2 = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [NP-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*4-1:0]  req_be;
  logic [NP*32-1:0] req_wdata;
  logic [31:0]      rsp_rdata, sram_data_o;
  logic [31:0]      sram_data_i = 32'h0;
  logic [AW-1:0]    sram_addr;
  logic [3:0]       sram_be_n;
  logic             sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, busy;

  sram_arb_ctrl #(.N_PORTS(NP), .ADDR_W(AW), .WAIT_CYCLES(W), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_data_o(sram_data_o),
    .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i), .busy(busy)
  );

  // ---------------- fixed-priority DUT ----------------
  logic [1:0]  f_valid, f_ready, f_we, f_rsp_valid;
  logic [39:0] f_addr;
  logic [7:0]  f_be;
  logic [63:0] f_wdata;
  logic [31:0] f_rdata, f_data_o, f_data_i;
  logic [19:0] f_sram_addr;
  logic [3:0]  f_be_n;
  logic        f_ce_n, f_oe_n, f_we_n, f_oe, f_busy;

  assign f_data_i = {12'h0, f_sram_addr};  // reads return their own address

  sram_arb_ctrl #(.N_PORTS(2), .ADDR_W(20), .WAIT_CYCLES(W2), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(f_valid), .req_ready(f_ready), .req_we(f_we),
    .req_addr(f_addr), .req_be(f_be), .req_wdata(f_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rdata),
    .sram_addr(f_sram_addr), .sram_be_n(f_be_n), .sram_ce_n(f_ce_n),
    .sram_oe_n(f_oe_n), .sram_we_n(f_we_n), .sram_data_o(f_data_o),
    .sram_data_oe(f_oe), .sram_data_i(f_data_i), .busy(f_busy)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- SRAM pad model ----------------
  logic [31:0] sram_mem [logic [19:0]];
  logic [31:0] ref_mem  [logic [19:0]];

  function automatic logic [31:0] init_val(input logic [19:0] a);
    return 32'h5A00_0000 ^ {a[11:0], a};
  endfunction

  function automatic logic [31:0] sram_rd(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Output data settles half a cycle after the strobes.
  always @(negedge clk) begin
    sram_data_i <= (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr) : 32'h0BAD_F00D;
  end

  always @(posedge clk) begin : sram_write
    logic [31:0] w;
    if (rst_n && !sram_ce_n && !sram_we_n && sram_data_oe) begin
      w = sram_rd(sram_addr);
      for (int j = 0; j < 4; j++) if (!sram_be_n[j]) w[j*8 +: 8] = sram_data_o[j*8 +: 8];
      sram_mem[sram_addr] = w;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int port; int t; bit we; logic [31:0] exp; } rsp_t;
  typedef struct { int port; int t; } gnt_t;

  rsp_t sb_q[$];
  gnt_t gnt_log[$];

  int          rr_ptr_m  = NP - 1;
  int          next_free = 0;
  bit          cur_act   = 0;
  int          cur_t     = -100;
  bit          cur_we    = 0;
  logic [19:0] cur_addr  = '0;
  logic [3:0]  cur_be    = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] last_rdata = '0;
  logic [NP-1:0] acc_last = '0;

  function automatic int rr_pick(input logic [NP-1:0] v, input int ptr);
    for (int k = 1; k <= NP; k++) if (v[(ptr + k) % NP]) return (ptr + k) % NP;
    return -1;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    rr_ptr_m   = NP - 1;
    next_free  = 0;
    cur_act    = 0;
    last_rdata = '0;
    acc_last   = '0;
  endtask

  always @(negedge clk) begin : monitor
    logic [63:0]   pe, pa;
    logic [NP-1:0] er;
    logic [31:0]   ed, old;
    rsp_t          e;
    int            k, p;
    bit            active;

    // Pin-level expectation for this cycle.
    active = cur_act && rst_n && (cyc >= cur_t + 1) && (cyc <= cur_t + 1 + W);
    if (active) begin
      k  = cyc - cur_t - 1;
      pe = {3'b0, 1'b1, 1'b0, cur_we, (cur_we ? (k == W) : 1'b1), cur_we,
            ~cur_be, cur_addr, (cur_we ? cur_wdata : 32'h0)};
      pa = {3'b0, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe,
            sram_be_n, sram_addr, (cur_we ? sram_data_o : 32'h0)};
    end else begin
      pe = {3'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 20'h0, 32'h0};
      pa = {3'b0, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, 4'h0, 20'h0, 32'h0};
    end
    check("pins", pa, pe);

    if (!rst_n) begin
      check("reset_rsp", {rsp_valid, rsp_rdata}, '0);
      acc_last = '0;
    end else begin
      // Responses, in accept order, due exactly W+2 cycles after accept.
      er = '0;
      if (sb_q.size() > 0 && sb_q[0].t + W + 2 == cyc) er[sb_q[0].port] = 1'b1;
      if (er != '0 || rsp_valid != '0) begin
        check("rsp_valid", rsp_valid, er);
        if (er != '0) begin
          e  = sb_q.pop_front();
          ed = e.we ? last_rdata : e.exp;
          check(e.we ? "rsp_rdata_after_write" : "rsp_rdata_read", rsp_rdata, ed);
          last_rdata = ed;
        end
      end

      // Arbitration: whenever the bank is free, the next round-robin winner.
      er = '0;
      if (cyc >= next_free && req_valid != '0) er[rr_pick(req_valid, rr_ptr_m)] = 1'b1;
      if (er != '0 || req_ready != '0) check("req_ready", req_ready, er);

      acc_last = req_valid & req_ready;
      if (acc_last != '0) begin
        p = 0;
        for (int i = NP - 1; i >= 0; i--) if (acc_last[i]) p = i;
        cur_act   = 1;
        cur_t     = cyc;
        cur_we    = req_we[p];
        cur_addr  = req_addr[p*AW +: AW];
        cur_be    = req_be[p*4 +: 4];
        cur_wdata = req_wdata[p*32 +: 32];
        if (cur_we) begin
          old = ref_rd(cur_addr);
          for (int j = 0; j < 4; j++) if (cur_be[j]) old[j*8 +: 8] = cur_wdata[j*8 +: 8];
          ref_mem[cur_addr] = old;
          ed = '0;
        end else begin
          ed = ref_rd(cur_addr);
        end
        sb_q.push_back('{port: p, t: cyc, we: cur_we, exp: ed});
        gnt_log.push_back('{port: p, t: cyc});
        rr_ptr_m  = p;
        next_free = cyc + W + 2;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input int p, input bit we, input logic [19:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    bit ok;
    ok = 0;
    req_we[p]              = we;
    req_addr[p*AW +: AW]   = a;
    req_be[p*4 +: 4]       = be;
    req_wdata[p*32 +: 32]  = d;
    req_valid[p]           = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_last[p]) begin
        ok = 1;
        break;
      end
    end
    req_valid[p] = 1'b0;
    check("accept_in_time", ok, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (sb_q.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req_valid[p] && !acc_last[p])) begin
          req_valid[p]          = ($urandom % 3) != 0;
          req_we[p]             = 1'($urandom % 2);
          req_addr[p*AW +: AW]  = ($urandom % 6 == 0) ? 20'h3FFFF : 20'($urandom % 8);
          req_be[p*4 +: 4]      = 4'($urandom);
          req_wdata[p*32 +: 32] = $urandom;
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic fp_test();
    int  p0, p1, t0;
    bit  got;
    p0 = 0; p1 = 0; t0 = 0; got = 0;
    f_addr  = {20'h2, 20'h1};
    f_we    = 2'b00;
    f_be    = 8'hFF;
    f_wdata = '0;
    f_valid = 2'b11;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (f_ready != 2'b00) begin
        check("fp_ready_port0_only", f_ready, 2'b01);
        if (f_ready[0]) p0++; else p1++;
      end
      if (f_rsp_valid != 2'b00) check("fp_rsp_port0", {f_rsp_valid, f_rdata}, {2'b01, 32'h1});
    end
    check("fp_port1_never_granted", p1, 0);
    check("fp_port0_throughput", p0 >= 5, 1);
    // Wait for the next port-0 accept, then withdraw port 0.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (f_ready == 2'b01) begin
        t0 = cyc;
        got = 1;
        break;
      end
    end
    check("fp_port0_accept_seen", got, 1);
    @(posedge clk); #1 f_valid = 2'b10;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (f_ready != 2'b00) begin
        check("fp_port1_ready", f_ready, 2'b10);
        check("fp_port1_next_idle", cyc - t0, W2 + 2);
        got = 1;
        break;
      end
    end
    check("fp_port1_granted", got, 1);
    @(posedge clk); #1 f_valid = 2'b00;
    got = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (f_rsp_valid == 2'b10) begin
        check("fp_port1_rdata", f_rdata, 32'h2);
        got = 1;
        break;
      end
    end
    check("fp_port1_rsp_seen", got, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    req_valid = '0; req_we = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    f_valid = '0; f_we = '0; f_addr = '0; f_be = '0; f_wdata = '0;
    sram_mem[20'h10] = 32'hDEADBEEF;
    ref_mem[20'h10]  = 32'hDEADBEEF;

    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read of a preloaded word.
    do_req(0, 1'b0, 20'h00010, 4'hF, 32'h0);
    wait_idle();

    // Partial write, then read back the merged word.
    do_req(0, 1'b1, 20'h00020, 4'b0011, 32'h12345678);
    wait_idle();
    do_req(0, 1'b0, 20'h00020, 4'hF, 32'h0);
    wait_idle();

    // Reset in the middle of a read: no response may follow.
    do_req(2, 1'b0, 20'h00010, 4'hF, 32'h0);
    @(posedge clk); #1;
    do_reset();
    repeat (W + 4) @(posedge clk);
    #1;
    do_req(1, 1'b0, 20'h00010, 4'hF, 32'h0);
    wait_idle();

    // Round-robin from reset with all ports requesting continuously.
    do_reset();
    gnt_log.delete();
    for (int p = 0; p < NP; p++) begin
      req_we[p] = 1'b0;
      req_addr[p*AW +: AW] = 20'(32'h100 + p);
      req_be[p*4 +: 4] = 4'hF;
    end
    req_valid = '1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (gnt_log.size() >= 6) begin
        ok = 1;
        break;
      end
    end
    req_valid = '0;
    check("rr_six_grants", ok, 1);
    if (ok) begin
      for (int i = 0; i < 6; i++) check("rr_order", gnt_log[i].port, i % NP);
      for (int i = 1; i < 6; i++) check("rr_spacing", gnt_log[i].t - gnt_log[i-1].t, W + 2);
    end
    wait_idle();

    // Back-to-back write then read at the top of the 18-bit range.
    gnt_log.delete();
    do_req(1, 1'b1, 20'h3FFFF, 4'hF, 32'hCAFE_0123);
    do_req(1, 1'b0, 20'h3FFFF, 4'hF, 32'h0);
    wait_idle();
    check("b2b_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) check("b2b_gap", gnt_log[1].t - gnt_log[0].t, W + 2);

    // Randomised traffic on all ports.
    random_phase(400);
    wait_idle();

    // Fixed-priority instance.
    fp_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
